// File: rtl/enc_rlwe_if.sv
// ============================================================================
// Module   : enc_rlwe_if
// Purpose  : Coefficient-stream bus between a Ring-LWE encryptor and its host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface enc_rlwe_if #(
  parameter int LOGP = 5
);
  logic            start;
  logic            in_valid;
  logic [LOGP-1:0] pk0_in;
  logic [LOGP-1:0] pk1_in;
  logic [LOGP-1:0] u_in;
  logic [LOGP-1:0] e1_in;
  logic [LOGP-1:0] e2_in;
  logic            m_in;
  logic            busy;
  logic            cipher_ready;
  logic [LOGP-1:0] c0_out;
  logic [LOGP-1:0] c1_out;
  logic            done;

  modport master (
    output start, in_valid, pk0_in, pk1_in, u_in, e1_in, e2_in, m_in,
    input  busy, cipher_ready, c0_out, c1_out, done
  );

  modport slave (
    input  start, in_valid, pk0_in, pk1_in, u_in, e1_in, e2_in, m_in,
    output busy, cipher_ready, c0_out, c1_out, done
  );
endinterface

`default_nettype wire

// File: rtl/enc_rlwe.sv
// ============================================================================
// Module   : enc_rlwe
// Purpose  : Ring-LWE encryption over Z_p[x]/(x^N+1), serial two-lane MAC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module enc_rlwe #(
  parameter int P    = 17,
  parameter int N    = 8,
  parameter int T    = 8,
  parameter int LOGP = $clog2(P),
  parameter int LOGN = $clog2(N)
) (
  input  wire logic   clk,
  input  wire logic   reset,
  enc_rlwe_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MUL = 2'd2, OUT = 2'd3} state_t;

  localparam logic [LOGP-1:0]   C_P    = LOGP'(P);
  localparam logic [LOGP-1:0]   C_T    = LOGP'(T);
  localparam logic [2*LOGP-1:0] C_P_W  = (2*LOGP)'(P);
  localparam logic [LOGN-1:0]   C_LAST = LOGN'(N - 1);
  localparam logic [LOGN:0]     C_NOUT = (LOGN + 1)'(N);

  state_t state_q, state_d;

  logic [LOGP-1:0] pk0_mem [N];
  logic [LOGP-1:0] pk1_mem [N];
  logic [LOGP-1:0] u_mem   [N];
  logic [LOGP-1:0] e1_mem  [N];
  logic [LOGP-1:0] e2_mem  [N];
  logic            m_mem   [N];
  logic [LOGP-1:0] c0_buf  [N];
  logic [LOGP-1:0] c1_buf  [N];

  logic [LOGN-1:0] k_q, i_q, j_q;
  logic [LOGN:0]   o_q;
  logic [LOGP-1:0] acc0_q, acc1_q;
  logic            busy_q, ready_q, done_q;
  logic [LOGP-1:0] c0_q, c1_q;

  function automatic logic [LOGP-1:0] add_mod(input logic [LOGP-1:0] a, input logic [LOGP-1:0] b);
    logic [LOGP:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, C_P}) s = s - {1'b0, C_P};
    return s[LOGP-1:0];
  endfunction

  // Negacyclic term: u[(i-j) mod N], negated when the index wrapped (j > i).
  logic [LOGN-1:0]   w_uidx;
  logic [LOGP-1:0]   w_uraw, w_uterm, w_red0, w_red1, w_acc0, w_acc1, w_c0, w_c1;
  logic [2*LOGP-1:0] w_prod0, w_prod1;

  always_comb begin
    w_uidx  = i_q - j_q;
    w_uraw  = u_mem[w_uidx];
    w_uterm = ((j_q > i_q) && (w_uraw != '0)) ? (C_P - w_uraw) : w_uraw;
    w_prod0 = {{LOGP{1'b0}}, pk0_mem[j_q]} * {{LOGP{1'b0}}, w_uterm};
    w_prod1 = {{LOGP{1'b0}}, pk1_mem[j_q]} * {{LOGP{1'b0}}, w_uterm};
    w_red0  = LOGP'(w_prod0 % C_P_W);
    w_red1  = LOGP'(w_prod1 % C_P_W);
    w_acc0  = add_mod(acc0_q, w_red0);
    w_acc1  = add_mod(acc1_q, w_red1);
    w_c0    = add_mod(add_mod(w_acc0, e1_mem[i_q]), m_mem[i_q] ? C_T : '0);
    w_c1    = add_mod(w_acc1, e2_mem[i_q]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (bus.in_valid && (k_q == C_LAST)) state_d = MUL;
      MUL:     if ((i_q == C_LAST) && (j_q == C_LAST)) state_d = OUT;
      OUT:     if (o_q == C_NOUT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      o_q     <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      c0_q    <= '0;
      c1_q    <= '0;
    end else begin
      busy_q  <= (state_d != IDLE);
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      c0_q    <= '0;
      c1_q    <= '0;
      case (state_q)
        IDLE: begin
          k_q    <= '0;
          i_q    <= '0;
          j_q    <= '0;
          o_q    <= '0;
          acc0_q <= '0;
          acc1_q <= '0;
        end
        LOAD: if (bus.in_valid) k_q <= k_q + LOGN'(1);
        MUL: begin
          j_q <= j_q + LOGN'(1);
          if (j_q == C_LAST) begin
            i_q    <= i_q + LOGN'(1);
            acc0_q <= '0;
            acc1_q <= '0;
          end else begin
            acc0_q <= w_acc0;
            acc1_q <= w_acc1;
          end
        end
        OUT: begin
          if (o_q != C_NOUT) begin
            ready_q <= 1'b1;
            c0_q    <= c0_buf[o_q[LOGN-1:0]];
            c1_q    <= c1_buf[o_q[LOGN-1:0]];
            o_q     <= o_q + (LOGN + 1)'(1);
          end else begin
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset: contents are only read after being written.
  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && bus.in_valid) begin
      pk0_mem[k_q] <= bus.pk0_in;
      pk1_mem[k_q] <= bus.pk1_in;
      u_mem[k_q]   <= bus.u_in;
      e1_mem[k_q]  <= bus.e1_in;
      e2_mem[k_q]  <= bus.e2_in;
      m_mem[k_q]   <= bus.m_in;
    end
    if ((state_q == MUL) && (j_q == C_LAST)) begin
      c0_buf[i_q] <= w_c0;
      c1_buf[i_q] <= w_c1;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.cipher_ready = ready_q;
  assign bus.done         = done_q;
  assign bus.c0_out       = c0_q;
  assign bus.c1_out       = c1_q;

endmodule

`default_nettype wire

// File: tb/tb_enc_rlwe.sv
// ============================================================================
// Module   : tb_enc_rlwe
// Purpose  : Self-checking bench for enc_rlwe against a polynomial-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enc_rlwe;
  localparam int P = 17;
  localparam int N = 8;
  localparam int T = 8;
  localparam int LOGP = 5;

  logic clk;
  logic reset;
  int   n_tot = 0;
  int   n_bad = 0;

  int pk0[N], pk1[N], uu[N], e1[N], e2[N], mm[N];
  int exp0[N], exp1[N];

  enc_rlwe_if #(.LOGP(LOGP)) bus ();

  enc_rlwe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int md(input int x);
    return ((x % P) + P) % P;
  endfunction

  // c = a*b in Z_p[x]/(x^N+1): x^N folds back as -1.
  task automatic model();
    int s0, s1;
    for (int i = 0; i < N; i++) begin
      s0 = 0;
      s1 = 0;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          if ((a + b) % N == i) begin
            s0 += ((a + b) >= N ? -1 : 1) * pk0[a] * uu[b];
            s1 += ((a + b) >= N ? -1 : 1) * pk1[a] * uu[b];
          end
      exp0[i] = md(s0 + e1[i] + (mm[i] != 0 ? T : 0));
      exp1[i] = md(s1 + e2[i]);
    end
  endtask

  task automatic garbage();
    bus.pk0_in = LOGP'($urandom_range(0, P - 1));
    bus.pk1_in = LOGP'($urandom_range(0, P - 1));
    bus.u_in   = LOGP'($urandom_range(0, P - 1));
    bus.e1_in  = LOGP'($urandom_range(0, P - 1));
    bus.e2_in  = LOGP'($urandom_range(0, P - 1));
    bus.m_in   = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_coef(input int k);
    bus.in_valid = 1'b1;
    bus.pk0_in   = LOGP'(pk0[k]);
    bus.pk1_in   = LOGP'(pk1[k]);
    bus.u_in     = LOGP'(uu[k]);
    bus.e1_in    = LOGP'(e1[k]);
    bus.e2_in    = LOGP'(e2[k]);
    bus.m_in     = 1'(mm[k]);
  endtask

  task automatic rand_all();
    for (int k = 0; k < N; k++) begin
      pk0[k] = $urandom_range(0, P - 1);
      pk1[k] = $urandom_range(0, P - 1);
      uu[k]  = $urandom_range(0, P - 1);
      e1[k]  = $urandom_range(0, P - 1);
      e2[k]  = $urandom_range(0, P - 1);
      mm[k]  = $urandom_range(0, 1);
    end
  endtask

  // mode: 0 gapless, 1 one gap before every coefficient, 2 random gaps.
  task automatic run_enc(input string nm, input int mode, input bit noise);
    int cyc, ngap, gap;
    model();
    tick();
    bus.in_valid = 1'b1;
    garbage();
    tick();
    bus.start    = 1'b1;
    bus.in_valid = noise;
    tick();
    bus.start = 1'b0;
    cyc  = 0;
    ngap = 0;
    for (int k = 0; k < N; k++) begin
      gap = (mode == 1) ? 1 : (mode == 2) ? $urandom_range(0, 2) : 0;
      repeat (gap) begin
        bus.in_valid = 1'b0;
        garbage();
        if (noise) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc++;
        ngap++;
      end
      drive_coef(k);
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    while (!bus.cipher_ready && cyc < 400) begin
      if (noise) begin
        bus.start    = (cyc % 5 == 0);
        bus.in_valid = 1'($urandom_range(0, 1));
        garbage();
      end
      tick();
      cyc++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    chk($sformatf("%s latency", nm), cyc, 1 + N + N * N + ngap);
    if (!bus.cipher_ready) return;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s ready[%0d]", nm, k), int'(bus.cipher_ready), 1);
      chk($sformatf("%s c0[%0d]", nm, k), int'(bus.c0_out), exp0[k]);
      chk($sformatf("%s c1[%0d]", nm, k), int'(bus.c1_out), exp1[k]);
      chk($sformatf("%s done_early[%0d]", nm, k), int'(bus.done), 0);
      tick();
    end
    chk($sformatf("%s done", nm), int'(bus.done), 1);
    chk($sformatf("%s busy_at_done", nm), int'(bus.busy), 0);
    chk($sformatf("%s ready_after", nm), int'(bus.cipher_ready), 0);
    chk($sformatf("%s c0_idle", nm), int'(bus.c0_out), 0);
    tick();
    chk($sformatf("%s done_pulse", nm), int'(bus.done), 0);
  endtask

  task automatic scen1();
    for (int k = 0; k < N; k++) begin
      pk0[k] = $urandom_range(0, P - 1);
      pk1[k] = $urandom_range(0, P - 1);
      uu[k] = 0; e1[k] = 0; e2[k] = 0;
    end
    mm = '{1, 0, 1, 1, 0, 0, 1, 0};
    exp0 = '{8, 0, 8, 8, 0, 0, 8, 0};
  endtask

  task automatic scen2();
    for (int k = 0; k < N; k++) begin
      uu[k] = (k == 0); pk0[k] = 3; e1[k] = 1; mm[k] = 1;
      pk1[k] = k + 1; e2[k] = 0;
    end
  endtask

  initial begin
    int anomalies;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    garbage();
    repeat (3) tick();
    chk("rst busy", int'(bus.busy), 0);
    chk("rst ready", int'(bus.cipher_ready), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst c0", int'(bus.c0_out), 0);
    chk("rst c1", int'(bus.c1_out), 0);
    @(negedge clk);
    reset = 1'b1;

    scen1();
    model();
    chk("s1 model c0[0]", exp0[0], 8);
    run_enc("s1", 0, 1'b0);

    scen2();
    run_enc("s2", 0, 1'b0);
    chk("s2 model c0[3]", exp0[3], 12);

    rand_all();
    uu = '{0, 1, 0, 0, 0, 0, 0, 0};
    pk1 = '{1, 2, 3, 4, 5, 6, 7, 8};
    for (int k = 0; k < N; k++) e2[k] = 0;
    run_enc("s3", 0, 1'b0);

    rand_all();
    for (int k = 0; k < N; k++) begin
      pk0[k] = 16; uu[k] = 16; e1[k] = 0; mm[k] = 0;
    end
    run_enc("s4", 0, 1'b0);

    scen2();
    run_enc("s5", 1, 1'b1);

    // Abort mid-MUL with an asynchronous reset, then confirm silence.
    scen1();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < N; k++) begin
      drive_coef(k);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (20) tick();
    chk("s6 busy_mid", int'(bus.busy), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("s6 busy_rst", int'(bus.busy), 0);
    chk("s6 ready_rst", int'(bus.cipher_ready), 0);
    chk("s6 done_rst", int'(bus.done), 0);
    chk("s6 c0_rst", int'(bus.c0_out), 0);
    chk("s6 c1_rst", int'(bus.c1_out), 0);
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b1;
    anomalies = 0;
    repeat (100) begin
      tick();
      if (bus.cipher_ready || bus.busy || bus.done) anomalies++;
    end
    chk("s6 quiet_after_release", anomalies, 0);
    scen1();
    run_enc("s6 rerun", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_all();
      run_enc($sformatf("rnd%0d", r), 2, 1'(r % 2));
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
